oam_dma_ctrl: RTL and testbench
===============================

# oam_dma_ctrl

Sprite-DMA controller and memory-bus arbiter between the CPU core and the single-port system memory. In normal operation it passes CPU accesses straight through to memory. A CPU write to the DMA trigger register ($4014) makes it stall the CPU (`cpu_stall_o` drives the PC block input) and take the bus. It then copies 256 bytes from CPU page `$XX00–$XXFF` to the OAM data port ($2004) and hands the bus back.

## Interface
Parameters:
- `MEM_ADDR_SIZE`, 16: memory address width.
- `DMA_TRIGGER_ADDR`, 16'h4014: write to this address starts DMA. The written byte is the source page.
- `OAM_DATA_ADDR`, 16'h2004: destination address for every DMA write.
- `XFER_LEN`, 256: bytes per transfer. Must be 256; the source offset is an 8-bit counter.

Ports:
- `clk_i`  in  1  clock.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `cpu_addr_i`  in  MEM_ADDR_SIZE  CPU access address.
- `cpu_wdata_i`  in  8  CPU write data.
- `cpu_we_i`  in  1  CPU write strobe.
- `cpu_stall_o`  out  1  freezes PC/control while DMA owns the bus.
- `dma_busy_o`  out  1  DMA in progress (any non-IDLE state).
- `mem_addr_o`  out  MEM_ADDR_SIZE  memory address.
- `mem_wdata_o`  out  8  memory write data.
- `mem_we_o`  out  1  memory write enable.
- `mem_rdata_i`  in  8  memory read data. Valid the cycle after the address is presented.

## Operation
- States: IDLE, HALT, ALIGN, RD, WR.
- **IDLE:** bus is a combinational pass-through.
  - `mem_addr_o = cpu_addr_i`, `mem_wdata_o = cpu_wdata_i`, `mem_we_o = cpu_we_i`.
  - Exception: a write to DMA_TRIGGER_ADDR is intercepted. `mem_we_o` is forced to 0, `cpu_wdata_i` is latched into `page_q`, `offs_q` is cleared to 0, and the next state is HALT.
- **HALT:** 1 dummy cycle. `mem_we_o = 0`, `mem_addr_o = cpu_addr_i`. Next state is ALIGN if `parity_q == 1`, else RD.
- **ALIGN:** 1 dummy cycle, same outputs as HALT. Next state is RD.
- **RD:** `mem_addr_o = {page_q, offs_q}`, `mem_we_o = 0`. Next state is WR.
- **WR:**
  - `mem_addr_o = OAM_DATA_ADDR`, `mem_wdata_o = mem_rdata_i` (data from the preceding RD address), `mem_we_o = 1`.
  - If `offs_q == 8'hFF`, next state is IDLE. Otherwise `offs_q` increments and the next state is RD.
- `parity_q`: free-running toggle flop. It is 0 on the first clock edge after reset release and toggles every cycle, DMA or not.
- `cpu_stall_o = dma_busy_o = (state != IDLE)`. Both are registered state decodes.
- While not IDLE, all CPU inputs are ignored, including further trigger writes.
- `offs_q` never wraps into the page field. The source address is always `{page_q, 8'hxx}`.
- A trigger write with page $20–$3F etc. is legal. Reads go to whatever address is formed.

## Timing
- Reset values: state IDLE, `page_q` 0, `offs_q` 0, `parity_q` 0. `cpu_stall_o` = 0, `dma_busy_o` = 0, `mem_we_o` = 0.
- While `rstn_i` is low, `mem_we_o` is forced to 0 even if `cpu_we_i = 1`.
- Trigger accepted in cycle T (IDLE, trigger write). `cpu_stall_o` rises in T+1.
- Stall duration: 513 cycles (HALT + 256×(RD, WR)) if `parity_q` = 0 in the HALT cycle. 514 cycles if it is 1.
- Last WR is in cycle T+513 or T+514. `cpu_stall_o` is low in the following cycle, and CPU accesses pass through that same cycle.
- Exactly 256 cycles with `mem_we_o = 1` per transfer, all to OAM_DATA_ADDR, in source-offset order 0..255.
- Reset mid-DMA: all outputs go to reset values immediately (async). No further writes. Post-reset the block is IDLE with the CPU un-stalled.
- Back-to-back: a trigger write in the first IDLE cycle after a DMA starts a new DMA normally.

## Test plan
- **Pass-through:** after reset, CPU writes `$55` to `$0300` then reads `$0300` -> `mem_we_o` = 1 with addr `$0300`, data `$55`; `cpu_stall_o` stays 0.
- **Even-parity DMA:** preload `$0200–$02FF` with `i^$A5`; trigger write `$02` to `$4014` with `parity_q` = 0 at HALT -> stall high exactly 513 cycles; 256 writes to `$2004` with data `$A5,$A4,…`; no write to `$4014` reaches memory.
- **Odd-parity DMA:** same, triggered one cycle later -> stall exactly 514 cycles; same 256-byte write sequence.
- **Ignored inputs:** during DMA, CPU drives `cpu_we_i` = 1 to `$4014` and `$0000` -> no extra memory writes; transfer count stays 256; `page_q` unchanged.
- **Reset mid-transfer:** assert `rstn_i` = 0 at write #100 -> `mem_we_o`, `cpu_stall_o`, `dma_busy_o` drop the same cycle; after release the block is IDLE and pass-through works.
- **Back-to-back:** trigger `$03` in the first cycle after the DMA ends -> second DMA starts and sources `$0300–$03FF`.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// ---------------------------------------------------------------------------------------------
// oam_dma_ctrl
//
// Sprite-DMA controller and memory-bus arbiter sitting between the CPU core and the single-port
// system memory. While idle, CPU accesses pass straight through to memory. A CPU write to the
// DMA trigger register takes the bus away from the CPU. The block then stalls the CPU and copies
// XFER_LEN bytes from the source page {page, 8'h00..8'hFF} to the OAM data port, one read/write
// pair per byte. When the last byte is written, the bus goes back to the CPU.
//
// Ports
//   clk_i        in   clock
//   rstn_i       in   asynchronous active-low reset (also gates mem_we_o while low)
//   cpu_addr_i   in   CPU access address
//   cpu_wdata_i  in   CPU write data (source page on a trigger write)
//   cpu_we_i     in   CPU write strobe
//   cpu_stall_o  out  freezes PC/control while the DMA owns the bus
//   dma_busy_o   out  DMA in progress (any state other than idle)
//   mem_addr_o   out  memory address
//   mem_wdata_o  out  memory write data
//   mem_we_o     out  memory write enable
//   mem_rdata_i  in   memory read data, valid the cycle after the address is presented
// ---------------------------------------------------------------------------------------------

module oam_dma_ctrl #(
    parameter int unsigned              MEM_ADDR_SIZE    = 16,
    parameter logic [MEM_ADDR_SIZE-1:0] DMA_TRIGGER_ADDR = 16'h4014,
    parameter logic [MEM_ADDR_SIZE-1:0] OAM_DATA_ADDR    = 16'h2004,
    // Must be 256: the source offset is an 8-bit counter that never carries into the page.
    parameter int unsigned              XFER_LEN         = 256
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,

    input  logic [MEM_ADDR_SIZE-1:0] cpu_addr_i,
    input  logic [7:0]               cpu_wdata_i,
    input  logic                     cpu_we_i,
    output logic                     cpu_stall_o,
    output logic                     dma_busy_o,

    output logic [MEM_ADDR_SIZE-1:0] mem_addr_o,
    output logic [7:0]               mem_wdata_o,
    output logic                     mem_we_o,
    input  logic [7:0]               mem_rdata_i
);

    localparam logic [7:0] LastOffs = 8'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StHalt,
        StAlign,
        StRd,
        StWr
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] page_q;
    logic [7:0] offs_q;
    logic       parity_q;

    logic       trig_hit;
    logic       last_byte;

    // Only an idle controller can accept a trigger; while busy every CPU input is ignored.
    assign trig_hit  = (state_q == StIdle) && cpu_we_i && (cpu_addr_i == DMA_TRIGGER_ADDR);
    assign last_byte = (offs_q == LastOffs);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers: source page, byte offset and the cycle-parity flop
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            page_q   <= 8'h00;
            offs_q   <= 8'h00;
            parity_q <= 1'b0;
        end else begin
            // Free-running: tracks odd/even bus cycles whether or not a DMA is running.
            parity_q <= ~parity_q;
            if (trig_hit) begin
                page_q <= cpu_wdata_i;
                offs_q <= 8'h00;
            end else if ((state_q == StWr) && !last_byte) begin
                offs_q <= offs_q + 8'h01;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (trig_hit) begin
                    state_d = StHalt;
                end
            end
            StHalt: begin
                // An odd cycle at HALT costs one extra alignment cycle before the first read.
                state_d = parity_q ? StAlign : StRd;
            end
            StAlign: begin
                state_d = StRd;
            end
            StRd: begin
                state_d = StWr;
            end
            StWr: begin
                state_d = last_byte ? StIdle : StRd;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr_o  = cpu_addr_i;
        mem_wdata_o = cpu_wdata_i;
        mem_we_o    = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Pass-through; the trigger write itself never reaches memory, and nothing is
                // written while reset is held.
                mem_we_o = cpu_we_i && !trig_hit && rstn_i;
            end
            StHalt, StAlign: begin
                mem_we_o = 1'b0;
            end
            StRd: begin
                mem_addr_o = MEM_ADDR_SIZE'({page_q, offs_q});
            end
            StWr: begin
                // Read data belongs to the address presented during the preceding RD cycle.
                mem_addr_o  = OAM_DATA_ADDR;
                mem_wdata_o = mem_rdata_i;
                mem_we_o    = 1'b1;
            end
            default: begin
                mem_we_o = 1'b0;
            end
        endcase
    end

    assign dma_busy_o  = (state_q != StIdle);
    assign cpu_stall_o = dma_busy_o;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// ---------------------------------------------------------------------------------------------
// tb_oam_dma_ctrl
//
// Self-checking bench for oam_dma_ctrl. A byte-array memory model answers reads one cycle
// late. Each DMA's expected write stream is a snapshot of the source page taken at trigger
// time. Its expected stall length comes from the parity of the clock edge count since reset
// release. Inputs change 1 ns after the rising edge and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------------------------

module tb_oam_dma_ctrl;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [15:0] cpu_addr_i;
    logic [7:0]  cpu_wdata_i;
    logic        cpu_we_i;
    logic        cpu_stall_o;
    logic        dma_busy_o;
    logic [15:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic        mem_we_o;
    logic [7:0]  mem_rdata_i;

    logic [7:0]  mem_model [0:65535];
    int unsigned edges;
    int          checks = 0;
    int          errors = 0;

    oam_dma_ctrl dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_stall_o (cpu_stall_o),
        .dma_busy_o  (dma_busy_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_we_o    (mem_we_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Rising edges since reset release; parity_q in any cycle equals edges % 2.
    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) edges <= 0;
        else         edges <= edges + 1;
    end

    // Single-port memory: synchronous write, read data one cycle after the address.
    always @(posedge clk_i) begin
        mem_rdata_i <= mem_model[mem_addr_o];
        if (mem_we_o) mem_model[mem_addr_o] <= mem_wdata_o;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic we);
        @(posedge clk_i);
        #1;
        cpu_addr_i  = a;
        cpu_wdata_i = d;
        cpu_we_i    = we;
    endtask

    // Outputs must mirror the CPU inputs with the CPU un-stalled.
    task automatic pt_check(input string tag);
        check_eq(tag, {7'd0, cpu_stall_o, mem_we_o, mem_addr_o, mem_wdata_o},
                 {7'd0, 1'b0, cpu_we_i, cpu_addr_i, cpu_wdata_i});
    endtask

    task automatic pt_random(input string tag);
        logic [15:0] a;
        a = 16'h8000 | 16'($urandom);
        drive(a, 8'($urandom), 1'($urandom));
        @(negedge clk_i);
        pt_check(tag);
    endtask

    // want_par: 0/1 forces parity at HALT, 2 accepts either. follow_page >= 0 issues a
    // back-to-back trigger in the first idle cycle; the task then returns right after driving it.
    task automatic run_dma(input logic [7:0] page, input bit noisy, input bit pretrig,
                           input int want_par, input int follow_page);
        logic [7:0]  exp_data [256];
        logic [15:0] a;
        int          par, len, stall_cnt, busy_bad, wcnt, j;
        if (!pretrig) begin
            if (want_par != 2) begin
                drive(16'h9000, 8'h00, 1'b0);
                if (int'(edges % 2) != want_par) drive(16'h9001, 8'h00, 1'b0);
            end
            drive(16'h4014, page, 1'b1);
        end
        par = int'((edges + 1) % 2);
        len = 513 + par;
        for (int i = 0; i < 256; i++) exp_data[i] = mem_model[{page, 8'(i)}];
        @(negedge clk_i);
        check_eq("trig_intercept", {cpu_stall_o, mem_we_o, mem_addr_o}, {2'b00, 16'h4014});

        stall_cnt = 0; busy_bad = 0; wcnt = 0;
        for (int k = 1; k <= len; k++) begin
            if (noisy) begin
                case ($urandom_range(0, 2))
                    0:       a = 16'h4014;
                    1:       a = 16'h0000;
                    default: a = 16'($urandom);
                endcase
                drive(a, 8'($urandom), 1'($urandom));
            end else begin
                drive(16'($urandom), 8'($urandom), 1'b0);
            end
            @(negedge clk_i);
            if (cpu_stall_o) stall_cnt++;
            if (dma_busy_o !== cpu_stall_o) busy_bad++;
            j = k - 2 - par;
            if (k == 1 || (par == 1 && k == 2)) begin
                check_eq("halt_bus", {mem_we_o, mem_addr_o}, {1'b0, cpu_addr_i});
            end else if (j >= 0 && j % 2 == 0) begin
                check_eq($sformatf("rd_addr%0d", j / 2), {mem_we_o, mem_addr_o},
                         {1'b0, page, 8'(j / 2)});
            end
            if (mem_we_o) begin
                if (wcnt < 256)
                    check_eq($sformatf("oam_wr%0d", wcnt), {mem_addr_o, mem_wdata_o},
                             {16'h2004, exp_data[wcnt]});
                wcnt++;
            end
        end
        check_eq("stall_len", stall_cnt, len);
        check_eq("busy_eq_stall", busy_bad, 0);
        check_eq("wr_count", wcnt, 256);

        if (follow_page >= 0) begin
            drive(16'h4014, 8'(follow_page), 1'b1);
        end else begin
            drive(16'h8123, 8'($urandom), 1'b1);
            @(negedge clk_i);
            pt_check("post_dma_pt");
        end
    endtask

    task automatic reset_mid_dma();
        int wcnt;
        wcnt = 0;
        drive(16'h4014, 8'h05, 1'b1);
        for (int k = 0; k < 600 && wcnt < 100; k++) begin
            drive(16'h0300, 8'h77, 1'b1);
            @(negedge clk_i);
            if (mem_we_o) wcnt++;
        end
        check_eq("rst_wr100_reached", wcnt, 100);
        #1 rstn_i = 1'b0;
        #1 check_eq("rst_async_drop", {mem_we_o, cpu_stall_o, dma_busy_o}, 3'b000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check_eq("rst_hold_quiet", {mem_we_o, cpu_stall_o, dma_busy_o}, 3'b000);
        end
        rstn_i = 1'b1;
        for (int k = 0; k < 4; k++) pt_random("post_rst_pt");
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem_model[i] = 8'($urandom);
        for (int i = 0; i < 256; i++)   mem_model[16'h0200 + i] = 8'(i) ^ 8'hA5;

        rstn_i      = 1'b0;
        cpu_addr_i  = 16'h0300;
        cpu_wdata_i = 8'h55;
        cpu_we_i    = 1'b1;
        #2;
        check_eq("reset_outputs", {mem_we_o, cpu_stall_o, dma_busy_o}, 3'b000);
        repeat (3) @(negedge clk_i);
        check_eq("reset_we_gated", {mem_we_o, mem_addr_o}, {1'b0, 16'h0300});
        rstn_i = 1'b1;

        drive(16'h0300, 8'h55, 1'b1);
        @(negedge clk_i);
        check_eq("pt_write", {cpu_stall_o, mem_we_o, mem_addr_o, mem_wdata_o},
                 {2'b01, 16'h0300, 8'h55});
        drive(16'h0300, 8'h00, 1'b0);
        @(negedge clk_i);
        check_eq("pt_read_addr", {cpu_stall_o, mem_we_o, mem_addr_o}, {2'b00, 16'h0300});
        @(posedge clk_i) #1;
        check_eq("pt_read_data", mem_rdata_i, 8'h55);
        for (int i = 0; i < 12; i++) pt_random("pt_rand");

        run_dma(8'h02, 1'b0, 1'b0, 0, -1);
        run_dma(8'h02, 1'b0, 1'b0, 1, -1);
        run_dma(8'(4 + $urandom_range(0, 27)), 1'b1, 1'b0, 2, 3);
        run_dma(8'h03, 1'b0, 1'b1, 2, -1);
        reset_mid_dma();
        run_dma(8'h02, 1'b1, 1'b0, 2, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
